// File: rtl/serial_port_ctrl_if.sv
// CPU register-bus bundle for the serial port controller.
//   cpu_addr  : 16-bit CPU address
//   cpu_wr    : one-cycle write strobe
//   cpu_din   : write data
//   cpu_dout  : read data (combinational from the slave)
//   cpu_hit   : slave decodes cpu_addr as one of its registers
// master = CPU side, slave = serial port controller.
interface serial_port_ctrl_if;
  logic [15:0] cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_hit;

  modport master (output cpu_addr, cpu_wr, cpu_din, input cpu_dout, cpu_hit);
  modport slave  (input cpu_addr, cpu_wr, cpu_din, output cpu_dout, cpu_hit);
endinterface

// File: rtl/serial_port_ctrl.sv
// Link-cable serial port controller (SB/SC registers).
// Runs 8-bit transfers: a bit is shifted out on each falling serial-clock
// edge and one is shifted in on the following rising edge. The serial clock
// is either the internal divider clock (sclk_int) or the partner's clock
// (sck_in, synchronised here). irq_serial pulses for one cycle on completion.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   bus         : CPU register bus (slave modport), cpu_dout/cpu_hit comb.
//   sclk_int    : internal serial clock, synchronous to clk
//   sck_in      : external serial clock, asynchronous
//   sck_out     : serial clock driven to partner (1 unless internal+active)
//   sd_in/sd_out: serial data in / out
//   irq_serial  : one-cycle completion pulse
//   busy        : transfer in progress (SC start bit)
module serial_port_ctrl #(
  parameter logic [15:0] SB_ADDR     = 16'hFF01,
  parameter logic [15:0] SC_ADDR     = 16'hFF02,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  serial_port_ctrl_if.slave  bus,
  input  logic               sclk_int,
  input  logic               sck_in,
  output logic               sck_out,
  input  logic               sd_in,
  output logic               sd_out,
  output logic               irq_serial,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, WAIT_FALL, WAIT_RISE, DONE} state_t;

  state_t                 state;
  logic [7:0]             sb;
  logic                   start;
  logic                   clksel;
  logic [2:0]             bit_cnt;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic                   clk_q;

  logic sb_wr, sc_wr, active, mid_xfer;
  logic clksel_nxt, sck_ext, cur, cur_nxt, fall, rise;

  assign sb_wr    = bus.cpu_wr && (bus.cpu_addr == SB_ADDR);
  assign sc_wr    = bus.cpu_wr && (bus.cpu_addr == SC_ADDR);
  assign active   = (state != IDLE);
  assign mid_xfer = (state == WAIT_FALL) || (state == WAIT_RISE);
  assign sck_ext  = sck_sync[SYNC_STAGES-1];

  // clksel changes on any SC write except a start request mid-transfer,
  // which is ignored entirely.
  always_comb begin
    clksel_nxt = clksel;
    if (sc_wr && !(bus.cpu_din[7] && mid_xfer))
      clksel_nxt = bus.cpu_din[0];
  end

  assign cur     = clksel     ? sclk_int : sck_ext;
  assign cur_nxt = clksel_nxt ? sclk_int : sck_ext;
  // clk_q tracks the source that will be selected next cycle, so switching
  // clocks never fabricates an edge; a low phase already in progress at start
  // is therefore skipped and the transfer begins at a genuine falling edge.
  assign fall    = clk_q & ~cur;
  assign rise    = ~clk_q & cur;

  assign busy        = start;
  assign bus.cpu_hit = (bus.cpu_addr == SB_ADDR) || (bus.cpu_addr == SC_ADDR);

  always_comb begin
    bus.cpu_dout = 8'hFF;
    if (bus.cpu_addr == SB_ADDR)      bus.cpu_dout = sb;
    else if (bus.cpu_addr == SC_ADDR) bus.cpu_dout = {start, 6'b111111, clksel};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sb         <= 8'h00;
      start      <= 1'b0;
      clksel     <= 1'b0;
      bit_cnt    <= 3'd0;
      sck_sync   <= '1;
      clk_q      <= 1'b1;
      sd_out     <= 1'b1;
      sck_out    <= 1'b1;
      irq_serial <= 1'b0;
    end else begin
      sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck_in};
      clk_q      <= cur_nxt;
      clksel     <= clksel_nxt;
      sck_out    <= (active && clksel) ? sclk_int : 1'b1;
      irq_serial <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sb_wr) sb <= bus.cpu_din;
          if (sc_wr && bus.cpu_din[7]) begin
            start   <= 1'b1;
            bit_cnt <= 3'd0;
            state   <= WAIT_FALL;
          end
        end
        WAIT_FALL, WAIT_RISE: begin
          if (sc_wr && !bus.cpu_din[7]) begin
            // abort: SB keeps whatever has been shifted so far
            start  <= 1'b0;
            sd_out <= 1'b1;
            state  <= IDLE;
          end else if (state == WAIT_FALL) begin
            if (fall) begin
              sd_out <= sb[7];
              state  <= WAIT_RISE;
            end
          end else if (rise) begin
            sb      <= {sb[6:0], sd_in};
            bit_cnt <= bit_cnt + 3'd1;
            state   <= (bit_cnt == 3'd7) ? DONE : WAIT_FALL;
          end
        end
        DONE: begin
          irq_serial <= 1'b1;
          sd_out     <= 1'b1;
          if (sc_wr && bus.cpu_din[7]) begin
            // back-to-back transfer: start stays set
            bit_cnt <= 3'd0;
            state   <= WAIT_FALL;
          end else begin
            start <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_port_ctrl.sv
module tb_serial_port_ctrl;
  localparam int SYNC     = 2;
  localparam int HALF_INT = 256;
  localparam int HALF_EXT = 16;
  localparam logic [15:0] SB = 16'hFF01;
  localparam logic [15:0] SC = 16'hFF02;

  logic clk = 1'b0, reset = 1'b1;
  logic sclk_int = 1'b1, sck_in = 1'b1, sd_in = 1'b1;
  logic sck_out, sd_out, irq_serial, busy;

  serial_port_ctrl_if bus();

  serial_port_ctrl #(.SB_ADDR(SB), .SC_ADDR(SC), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .sclk_int(sclk_int), .sck_in(sck_in), .sck_out(sck_out),
    .sd_in(sd_in), .sd_out(sd_out), .irq_serial(irq_serial), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int irq_pulses = 0, irq_hi = 0, sck_low_ext = 0;
  logic irq_prev = 1'b0;
  bit ext_watch = 1'b0;
  bit exp_q[$];

  always @(negedge clk) begin
    if (irq_serial === 1'b1) irq_hi <= irq_hi + 1;
    if (irq_serial === 1'b1 && irq_prev !== 1'b1) irq_pulses <= irq_pulses + 1;
    irq_prev <= irq_serial;
    if (ext_watch && sck_out !== 1'b1) sck_low_ext <= sck_low_ext + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cpu_addr = a; bus.cpu_din = d; bus.cpu_wr = 1'b1;
    @(negedge clk);
    bus.cpu_wr = 1'b0; bus.cpu_addr = 16'h0000;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d, output logic h);
    bus.cpu_addr = a;
    #1;
    d = bus.cpu_dout;
    h = bus.cpu_hit;
  endtask

  task automatic read_check(input string name, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] d;
    logic h;
    cpu_read(a, d, h);
    check(name, 32'(d), 32'(exp));
  endtask

  task automatic set_sck(input bit ext, input logic v);
    if (ext) sck_in = v; else sclk_int = v;
  endtask

  // Drive n serial-clock periods (fall then rise) feeding pat MSB first from
  // bit index 'first'; sd_out is compared against the scoreboard just before
  // each rise.
  task automatic xfer(input bit ext, input logic [7:0] pat, input int first,
                      input int n, input bit chk_lag);
    int half, lag;
    bit e;
    half = ext ? HALF_EXT : HALF_INT;
    lag  = ext ? SYNC + 1 : 1;
    for (int i = first; i < first + n; i++) begin
      @(negedge clk);
      check("sck_out_high_phase", 32'(sck_out), 1);
      set_sck(ext, 1'b0);
      sd_in = pat[7-i];
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sd_queue: empty, expected a pending bit");
        e = 1'b1;
      end else e = exp_q.pop_front();
      if (chk_lag && i == first) begin
        repeat (lag - 1) @(negedge clk);
        check("ext_lag_before", 32'(sd_out), 1);
        @(negedge clk);
        check("ext_lag_after", 32'(sd_out), 32'(e));
        repeat (half - lag) @(negedge clk);
      end else repeat (half) @(negedge clk);
      check("sd_out_bit", 32'(sd_out), 32'(e));
      check("sck_out_low_phase", 32'(sck_out), ext ? 1 : 0);
      set_sck(ext, 1'b1);
      repeat (half - 1) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    bit          wr;
    logic [7:0]  din;
    logic [7:0]  exp_dout;
    bit          exp_hit;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int base;
    bit e;
    logic [7:0] d;
    logic h;

    tbl[0] = '{16'hFF01, 1'b0, 8'h00, 8'h00, 1'b1};
    tbl[1] = '{16'hFF02, 1'b0, 8'h00, 8'h7E, 1'b1};
    tbl[2] = '{16'hFF03, 1'b0, 8'h00, 8'hFF, 1'b0};
    tbl[3] = '{16'hFF00, 1'b0, 8'h00, 8'hFF, 1'b0};
    tbl[4] = '{16'hFF01, 1'b1, 8'h5A, 8'h5A, 1'b1};
    tbl[5] = '{16'hFF02, 1'b1, 8'h01, 8'h7F, 1'b1};
    tbl[6] = '{16'hFF02, 1'b1, 8'h00, 8'h7E, 1'b1};
    tbl[7] = '{16'h0000, 1'b0, 8'h00, 8'hFF, 1'b0};

    bus.cpu_addr = 16'h0000; bus.cpu_wr = 1'b0; bus.cpu_din = 8'h00;

    // reset
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_sd_out", 32'(sd_out), 1);
    check("rst_sck_out", 32'(sck_out), 1);
    check("rst_irq", 32'(irq_serial), 0);
    check("rst_busy", 32'(busy), 0);
    read_check("rst_sc", SC, 8'h7E);
    read_check("rst_sb", SB, 8'h00);

    // register table
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].wr) cpu_write(tbl[i].addr, tbl[i].din);
      cpu_read(tbl[i].addr, d, h);
      check($sformatf("tbl%0d_dout", i), 32'(d), 32'(tbl[i].exp_dout));
      check($sformatf("tbl%0d_hit", i), 32'(h), 32'(tbl[i].exp_hit));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 0);
    end

    // internal transfer, started in the middle of a low phase
    base = irq_pulses;
    cpu_write(SB, 8'hA5);
    push_byte(8'hA5);
    sclk_int = 1'b0;
    cpu_write(SC, 8'h81);
    check("int_busy", 32'(busy), 1);
    repeat (HALF_INT) @(negedge clk);
    check("int_partial_low_sd", 32'(sd_out), 1);
    sclk_int = 1'b1;
    repeat (HALF_INT - 1) @(negedge clk);
    xfer(1'b0, 8'h3C, 0, 8, 1'b0);
    repeat (4) @(negedge clk);
    check("int_busy_end", 32'(busy), 0);
    read_check("int_sb", SB, 8'h3C);
    read_check("int_sc", SC, 8'h7F);
    check("int_irq_count", 32'(irq_pulses - base), 1);
    check("int_sd_idle", 32'(sd_out), 1);

    // external transfer
    base = irq_pulses;
    cpu_write(SB, 8'h4B);
    push_byte(8'h4B);
    cpu_write(SC, 8'h80);
    ext_watch = 1'b1;
    xfer(1'b1, 8'hD2, 0, 8, 1'b1);
    repeat (4) @(negedge clk);
    ext_watch = 1'b0;
    check("ext_busy_end", 32'(busy), 0);
    read_check("ext_sb", SB, 8'hD2);
    read_check("ext_sc", SC, 8'h7E);
    check("ext_irq_count", 32'(irq_pulses - base), 1);
    check("ext_sck_out_low_cycles", 32'(sck_low_ext), 0);

    // abort after 3 rises
    base = irq_pulses;
    cpu_write(SB, 8'hC3);
    push_byte(8'hC3);
    cpu_write(SC, 8'h81);
    xfer(1'b0, 8'hA0, 0, 3, 1'b0);
    cpu_write(SC, 8'h01);
    check("abort_busy", 32'(busy), 0);
    check("abort_sd_out", 32'(sd_out), 1);
    exp_q.delete();
    for (int k = 0; k < 20; k++) begin
      sclk_int = 1'b0; repeat (HALF_INT) @(negedge clk);
      sclk_int = 1'b1; repeat (HALF_INT) @(negedge clk);
    end
    check("abort_no_irq", 32'(irq_pulses - base), 0);
    check("abort_sd_out_late", 32'(sd_out), 1);
    read_check("abort_sb", SB, 8'h1D);
    read_check("abort_sc", SC, 8'h7F);

    // writes during a transfer are ignored
    base = irq_pulses;
    cpu_write(SB, 8'h96);
    push_byte(8'h96);
    cpu_write(SC, 8'h81);
    xfer(1'b0, 8'h5A, 0, 2, 1'b0);
    cpu_write(SB, 8'hFF);
    cpu_write(SC, 8'h81);
    read_check("ign_sc_busy", SC, 8'hFF);
    cpu_read(16'hFF03, d, h);
    check("ign_ff03_dout", 32'(d), 32'hFF);
    check("ign_ff03_hit", 32'(h), 0);
    xfer(1'b0, 8'h5A, 2, 6, 1'b0);
    repeat (4) @(negedge clk);
    check("ign_busy_end", 32'(busy), 0);
    read_check("ign_sb", SB, 8'h5A);
    check("ign_irq_count", 32'(irq_pulses - base), 1);

    // restart written in the same cycle as completion
    base = irq_pulses;
    cpu_write(SB, 8'hE1);
    push_byte(8'hE1);
    cpu_write(SC, 8'h81);
    xfer(1'b0, 8'h69, 0, 7, 1'b0);
    @(negedge clk);
    sclk_int = 1'b0;
    sd_in = 1'b1;                      // bit 0 of 8'h69
    e = exp_q.pop_front();
    repeat (HALF_INT) @(negedge clk);
    check("rst8_sd_out", 32'(sd_out), 32'(e));
    sclk_int = 1'b1;
    @(negedge clk);                    // last rise taken, completion cycle next
    bus.cpu_addr = SC; bus.cpu_din = 8'h81; bus.cpu_wr = 1'b1;
    @(negedge clk);
    bus.cpu_wr = 1'b0; bus.cpu_addr = 16'h0000;
    check("restart_irq", 32'(irq_serial), 1);
    check("restart_busy", 32'(busy), 1);
    push_byte(8'h69);
    @(negedge clk);
    check("restart_irq_width", 32'(irq_serial), 0);
    read_check("restart_sb", SB, 8'h69);
    xfer(1'b0, 8'h0F, 0, 8, 1'b0);
    repeat (4) @(negedge clk);
    check("restart_busy_end", 32'(busy), 0);
    read_check("restart_sb_end", SB, 8'h0F);
    check("restart_irq_count", 32'(irq_pulses - base), 2);

    // reset in the middle of a transfer
    base = irq_pulses;
    cpu_write(SB, 8'h3C);
    push_byte(8'h3C);
    cpu_write(SC, 8'h81);
    xfer(1'b0, 8'hFF, 0, 5, 1'b0);
    @(negedge clk);
    sclk_int = 1'b0;
    e = exp_q.pop_front();
    repeat (4) @(negedge clk);
    check("mid_sck_out_low", 32'(sck_out), 0);
    check("mid_sd_out", 32'(sd_out), 32'(e));
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_sd_out", 32'(sd_out), 1);
    check("mid_rst_sck_out", 32'(sck_out), 1);
    check("mid_rst_irq", 32'(irq_serial), 0);
    check("mid_rst_busy", 32'(busy), 0);
    read_check("mid_rst_sb", SB, 8'h00);
    read_check("mid_rst_sc", SC, 8'h7E);
    reset = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      sclk_int = 1'b1; repeat (HALF_INT) @(negedge clk);
      sclk_int = 1'b0; repeat (HALF_INT) @(negedge clk);
    end
    check("mid_rst_no_irq", 32'(irq_pulses - base), 0);
    check("mid_rst_busy_late", 32'(busy), 0);

    @(negedge clk);
    check("irq_single_cycle", 32'(irq_hi), 32'(irq_pulses));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_port_ctrl.md
Name: serial_port_ctrl

Overview:
Controller for the link-cable serial port, mapped at registers SB (0xFF01) and SC (0xFF02). It sequences 8-bit transfers that shift out on the falling serial-clock edge and shift in on the rising edge. The serial clock is either the internal 8.192 kHz clock from the serial clock divider or an external clock from the link partner. On completion it raises the serial interrupt request.

Parameters:
SB_ADDR, 16'hFF01, address of the shift data register
SC_ADDR, 16'hFF02, address of the serial control register
SYNC_STAGES, 2, flip-flop stages for synchronising sck_in (>=2)

Ports:
clk  in  1  system clock, 4.194304 MHz
reset  in  1  synchronous, active-high reset
cpu_addr  in  16  CPU address
cpu_wr  in  1  write strobe, one cycle per write
cpu_din  in  8  write data
cpu_dout  out  8  read data; combinational
cpu_hit  out  1  high when cpu_addr equals SB_ADDR or SC_ADDR
sclk_int  in  1  divider clk_out, synchronous to clk
sck_in  in  1  external serial clock, asynchronous
sck_out  out  1  serial clock driven to the partner
sd_in  in  1  serial data in, sampled on rising serial-clock edge
sd_out  out  1  serial data out
irq_serial  out  1  one-cycle interrupt request pulse
busy  out  1  high while SC[7] is set

Behaviour:
- Reset:
  - SB=8'h00, SC start bit=0, clock select=0, bit counter=0, state IDLE.
  - sd_out=1, sck_out=1, irq_serial=0, synchroniser and edge registers=1.
- Register reads:
  - SB_ADDR returns SB.
  - SC_ADDR returns {start, 6'b111111, clksel}.
  - Any other address returns 8'hFF.
- Clock source: clksel=1 uses sclk_int; clksel=0 uses sck_in after SYNC_STAGES flops.
- Edge detection:
  - The selected clock is registered into clk_q.
  - fall = clk_q & ~cur; rise = ~clk_q & cur; each lasts one cycle.
- sck_out is registered. It equals sclk_int while in an active state with clksel=1; otherwise it is 1.
- State machine:
  - IDLE: on SC write with din[7]=1, latch clksel=din[0], set start, clear bit counter, go to WAIT_FALL.
  - WAIT_FALL: on fall, sd_out<=SB[7], go to WAIT_RISE.
  - WAIT_RISE: on rise, SB<={SB[6:0],sd_in} and increment the bit counter. If the counter was 7, go to DONE; else go to WAIT_FALL.
  - DONE (one cycle): clear start, set sd_out=1, pulse irq_serial=1, go to IDLE.
- A transfer always begins at the first falling edge after start. A partial low phase already in progress is ignored.
- With the internal clock, one transfer takes 8×512 cycles plus start phase alignment.
- CPU writes while active (states other than IDLE):
  - SB writes are ignored.
  - SC write with din[7]=0 aborts: go to IDLE, clear start, set sd_out=1, no irq. SB keeps its partially shifted value. clksel<=din[0].
  - SC write with din[7]=1 is ignored entirely.
- Same-cycle SC write (din[7]=1) in DONE:
  - irq_serial still pulses.
  - A new transfer starts: start stays 1, state goes to WAIT_FALL, counter is cleared.
- In IDLE, an SC write with din[7]=0 only updates clksel. SB writes update SB.
- Reset mid-transfer returns every register and output to its reset value on the next edge, with no irq.
- Edges of the unselected clock have no effect. An external clock that never toggles leaves the transfer pending indefinitely; this is legal.
- busy = start.

Test Plan:
- Reset: assert reset for 3 cycles, then release. Required: sd_out=1, sck_out=1, irq_serial=0, SC reads 8'h7E, SB reads 8'h00.
- Internal transfer: write SB=8'hA5, then SC=8'h81; drive sd_in with bit pattern 8'h3C MSB first on rising edges. Required:
  - sd_out sequence 1,0,1,0,0,1,0,1 on successive falls.
  - After the 8th rise, SB=8'h3C and SC reads 8'h7F.
  - Exactly one irq_serial pulse; sck_out toggles every 256 clk while busy.
- External transfer: clksel=0 (SC=8'h80), toggle sck_in every 16 clk. Required:
  - Shifts occur SYNC_STAGES+1 cycles after each sck_in edge.
  - sck_out stays 1 throughout.
  - irq_serial pulses after 8 rises.
- Abort: start an internal transfer, and after 3 rises write SC=8'h01. Required: busy=0 next cycle, no irq_serial for 10000 cycles, sd_out=1, SB holds 3 shifted bits.
- Ignored writes: while busy, write SB=8'hFF and SC=8'h81. Required: the transfer result is unaffected. A read of 0xFF03 returns 8'hFF with cpu_hit=0.
- Reset mid-transfer after 5 rises. Required: all reset values restored, no irq_serial pulse.
